// File: rtl/npc_btb_predictor.sv
// Next-PC generator with a direct-mapped BTB and 2-bit saturating counters.
// Optional branch/mispredict statistics counters are enabled by defining BTB_STATS_EN.
module npc_btb_predictor #(
    parameter int unsigned ENTRY_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    input  logic        jal_id,
    input  logic [31:0] jal_target_id,
    input  logic        ex_valid,
    input  logic        br_ex,
    input  logic        br_taken_ex,
    input  logic [31:0] br_target_ex,
    input  logic [31:0] pc_ex,
    input  logic        pred_taken_ex,
    input  logic [31:0] pred_target_ex,
    input  logic        jalr_ex,
    input  logic [31:0] jalr_target_ex,
    output logic [31:0] NPC,
    output logic        pred_taken_f,
    output logic [31:0] pred_target_f,
    output logic        mispredict_ex
`ifdef BTB_STATS_EN
    ,
    output logic [31:0] br_cnt,
    output logic [31:0] mispred_cnt
`endif
);

    localparam int unsigned TAG_BITS = 32 - ENTRY_BITS - 2;
    localparam int unsigned ENTRIES  = 1 << ENTRY_BITS;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic [ENTRY_BITS-1:0] f_idx;
    logic [TAG_BITS-1:0]   f_tag;
    logic                  f_hit;
    logic [ENTRY_BITS-1:0] e_idx;
    logic [TAG_BITS-1:0]   e_tag;
    logic                  e_hit;
    logic                  train;
    logic                  mp_raw;
    logic                  taken_f_raw;

    assign f_idx = PCF[ENTRY_BITS+1:2];
    assign f_tag = PCF[31:ENTRY_BITS+2];
    assign e_idx = pc_ex[ENTRY_BITS+1:2];
    assign e_tag = pc_ex[31:ENTRY_BITS+2];

    assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign e_hit       = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign train       = ex_valid && br_ex;
    assign taken_f_raw = f_hit && ctr_q[f_idx][1];

    assign mp_raw = train &&
                    ((br_taken_ex != pred_taken_ex) ||
                     (br_taken_ex && pred_taken_ex && (br_target_ex != pred_target_ex)));

    // Lookup and redirect selection; everything is held at zero while in reset.
    always_comb begin
        pred_taken_f  = 1'b0;
        pred_target_f = '0;
        mispredict_ex = 1'b0;
        NPC           = '0;
        if (!rst) begin
            pred_taken_f  = taken_f_raw;
            pred_target_f = f_hit ? target_q[f_idx] : '0;
            mispredict_ex = mp_raw;
            if (mp_raw) begin
                NPC = br_taken_ex ? br_target_ex : (pc_ex + 32'd4);
            end else if (ex_valid && jalr_ex) begin
                NPC = jalr_target_ex;
            end else if (jal_id) begin
                NPC = jal_target_id;
            end else if (taken_f_raw) begin
                NPC = target_q[f_idx];
            end else begin
                NPC = PCF + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (train) begin
            if (e_hit) begin
                if (br_taken_ex) begin
                    ctr_q[e_idx]    <= (ctr_q[e_idx] == 2'b11) ? 2'b11 : ctr_q[e_idx] + 2'd1;
                    target_q[e_idx] <= br_target_ex;
                end else begin
                    ctr_q[e_idx] <= (ctr_q[e_idx] == 2'b00) ? 2'b00 : ctr_q[e_idx] - 2'd1;
                end
            end else if (br_taken_ex) begin
                valid_q[e_idx]  <= 1'b1;
                tag_q[e_idx]    <= e_tag;
                target_q[e_idx] <= br_target_ex;
                ctr_q[e_idx]    <= 2'b10;
            end
        end
    end

`ifdef BTB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt      <= '0;
            mispred_cnt <= '0;
        end else begin
            if (train && (br_cnt != '1)) begin
                br_cnt <= br_cnt + 32'd1;
            end
            if (mp_raw && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
